iob_skid_buf: RTL and testbench

IOB_SKID_BUF -- requirements
Module: iob_skid_buf

---
 rtl/iob_skid_buf_pkg.sv | 9 +
 rtl/iob_regr.sv | 16 +
 rtl/iob_skid_buf.sv | 64 ++++++
 tb/tb_iob_skid_buf.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/iob_skid_buf_pkg.sv
// iob_skid_buf_pkg: FSM state encoding and default parameters for iob_skid_buf
package iob_skid_buf_pkg;
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;
   localparam int DATA_W_DEF  = 32;
   localparam int RST_VAL_DEF = 0;
   localparam int CNT_W_DEF   = 16;
endpackage

// File: rtl/iob_regr.sv
// iob_regr: synchronous-reset register with clock enable and load enable
module iob_regr #(
   parameter int DATA_W = 32,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o
);
   always_ff @(posedge clk_i)
      if (rst_i) data_o <= RST_VAL;
      else if (cke_i && en_i) data_o <= data_i;
endmodule

// File: rtl/iob_skid_buf.sv
// iob_skid_buf: two-entry elastic stage (main + skid register) with registered in_ready_o.
// Defining IOB_SKID_BUF_CNT_EN adds the output-transfer counter port cnt_o.
module iob_skid_buf
   import iob_skid_buf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(RST_VAL_DEF),
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   input  logic              out_ready_i,
   output logic [1:0]        level_o
`ifdef IOB_SKID_BUF_CNT_EN
   ,
   output logic [CNT_W-1:0]  cnt_o
`endif
);
   logic [1:0]        state, state_d;
   logic [DATA_W-1:0] skid, main_d;
   logic              in_xfer, out_xfer, main_en, skid_en, state_en;

   // handshakes depend only on registered state, never on the opposite side
   assign in_ready_o  = cke_i & ~rst_i & (state != FULL);
   assign out_valid_o = cke_i & ~rst_i & (state != EMPTY);
   assign in_xfer     = in_valid_i & in_ready_o;
   assign out_xfer    = out_valid_o & out_ready_i;
   assign level_o     = state;

   always_comb begin
      main_en  = (in_xfer & (state == EMPTY | (state == BUSY & out_xfer))) | (out_xfer & state == FULL);
      main_d   = (state == FULL) ? skid : in_data_i;
      skid_en  = in_xfer & ~out_xfer & (state == BUSY);
      state_en = in_xfer | out_xfer;
      state_d  = (state != BUSY) ? BUSY : (in_xfer == out_xfer) ? BUSY : out_xfer ? EMPTY : FULL;
   end

   iob_regr #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) main_reg (
      .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i),
      .en_i(main_en), .data_i(main_d), .data_o(out_data_o)
   );

   iob_regr #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) skid_reg (
      .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i),
      .en_i(skid_en), .data_i(in_data_i), .data_o(skid)
   );

   iob_regr #(.DATA_W(2), .RST_VAL(EMPTY)) state_reg (
      .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i),
      .en_i(state_en), .data_i(state_d), .data_o(state)
   );

`ifdef IOB_SKID_BUF_CNT_EN
   always_ff @(posedge clk_i)
      if (rst_i) cnt_o <= '0;
      else if (out_xfer) cnt_o <= cnt_o + CNT_W'(1);
`endif
endmodule

// File: tb/tb_iob_skid_buf.sv
// tb_iob_skid_buf: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_iob_skid_buf;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam logic [DATA_W-1:0] RST_VAL = 32'h0;

   logic              clk = 0, cke = 1, rst = 1, in_valid = 0, out_ready = 0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready, out_valid;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        level;
`ifdef IOB_SKID_BUF_CNT_EN
   logic [CNT_W-1:0]  cnt;
`endif

   int checks = 0, failures = 0, pops = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic              stall_prev = 0;
   logic [DATA_W-1:0] data_prev = '0;

   iob_skid_buf #(.DATA_W(DATA_W), .RST_VAL(RST_VAL), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .cke_i(cke), .rst_i(rst),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
      .level_o(level)
`ifdef IOB_SKID_BUF_CNT_EN
      , .cnt_o(cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      in_valid = 1;
      in_data  = d;
      step();
      in_valid = 0;
   endtask

   // Monitor: inputs settle 1ns after posedge, so the negedge sees what the next edge will transfer
   always @(negedge clk) begin
      if (stall_prev && out_valid) chk("stable_data", out_data, data_prev);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_output", out_data, 32'hDEAD_BEEF);
         else chk("out_data_order", out_data, exp_q.pop_front());
         pops++;
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      step();
      step();
      rst = 0;
      #1;
      chk("rst_level", level, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, RST_VAL);
`ifdef IOB_SKID_BUF_CNT_EN
      chk("rst_cnt", cnt, 0);
`endif
      // single word, latency 1
      out_ready = 1;
      push(32'hA5);
      chk("a5_out_valid", out_valid, 1);
      chk("a5_out_data", out_data, 32'hA5);
      chk("a5_level", level, 1);
      step();
      chk("a5_drained", level, 0);
      // fill both entries, then drain
      out_ready = 0;
      push(32'h11);
      push(32'h22);
      chk("full_level", level, 2);
      chk("full_in_ready", in_ready, 0);
      chk("full_head", out_data, 32'h11);
      step();
      chk("full_hold_level", level, 2);
      out_ready = 1;
      step();
      chk("drain1_data", out_data, 32'h22);
      chk("drain1_level", level, 1);
      step();
      chk("drain2_level", level, 0);
      chk("drain2_out_valid", out_valid, 0);
      // streaming 100 words
      p0 = pops;
      in_valid = 1;
      for (int i = 0; i < 100; i++) begin
         in_data = i;
         step();
         chk("stream_level", level, 1);
         chk("stream_out_data", out_data, i);
      end
      in_valid = 0;
      step();
      chk("stream_pops", pops - p0, 100);
      chk("stream_end_level", level, 0);
      // clock enable freeze while full
      out_ready = 0;
      push(32'h33);
      push(32'h44);
      chk("cke_pre_level", level, 2);
      cke = 0;
      out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("cke_out_valid", out_valid, 0);
         chk("cke_in_ready", in_ready, 0);
         chk("cke_level", level, 2);
         chk("cke_out_data", out_data, 32'h33);
      end
      cke = 1;
      #1;
      chk("cke_resume_data", out_data, 32'h33);
      step();
      chk("cke_resume2_data", out_data, 32'h44);
      step();
      chk("cke_end_level", level, 0);
      // reset while full discards contents
      out_ready = 0;
      push(32'h55);
      push(32'h66);
      chk("rst2_pre_level", level, 2);
      rst = 1;
      out_ready = 1;
      #1;
      chk("rst2_no_out_valid", out_valid, 0);
      step();
      exp_q.delete();
      rst = 0;
      #1;
      chk("rst2_level", level, 0);
      chk("rst2_out_data", out_data, RST_VAL);
      chk("rst2_in_ready", in_ready, 1);
`ifdef IOB_SKID_BUF_CNT_EN
      chk("rst2_cnt", cnt, 0);
`endif
      // 17 output transfers: counter of width 4 wraps to 1
      in_valid = 1;
      for (int i = 0; i < 17; i++) begin
         in_data = 32'h100 + i;
         step();
      end
      in_valid = 0;
      step();
      chk("wrap_level", level, 0);
`ifdef IOB_SKID_BUF_CNT_EN
      chk("wrap_cnt", cnt, 1);
`endif
      step();
      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
